// File: rtl/debug_mailbox_pkg.sv
`default_nettype none
// ============================================================================
// Module   : debug_mailbox_pkg
// Purpose  : Shared constants and helpers for the debug mailbox Wishbone slave:
//            register word offsets, CON_STAT bit positions, default result
//            codes and a byte-lane merge helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package debug_mailbox_pkg;

  // Register word offsets (wb_adr_i[4:2])
  localparam logic [2:0] REG_RESULT   = 3'd0;
  localparam logic [2:0] REG_CONSOLE  = 3'd1;
  localparam logic [2:0] REG_CON_STAT = 3'd2;
  localparam logic [2:0] REG_CYCLES   = 3'd3;
  localparam logic [2:0] REG_WDT      = 3'd4;

  // CON_STAT layout: {overflow, 15'b0, count[15:0]}
  localparam int CON_STAT_OVF_BIT = 31;
  localparam int CON_STAT_CNT_MSB = 15;

  // Default result codes understood by the test harness
  localparam logic [31:0] DEFAULT_PASS_CODE = 32'd1;
  localparam logic [31:0] DEFAULT_FAIL_CODE = 32'd31;

  // Replace the bytes of old_val whose lane enable is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debug_mailbox_wb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with registered storage (no fall-through).
//            A push while full is accepted only when a pop happens in the same
//            cycle; otherwise it is ignored and the caller flags overflow.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            push, push_data - write request and data
//            pop             - read request (ignored when empty)
//            pop_data        - head entry (0 when empty)
//            full, empty     - occupancy flags
//            count           - entries held, 0..DEPTH
// Params   : WIDTH - entry width; DEPTH - entries, power of two >= 2
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Gate the head so an empty FIFO presents 0 rather than stale storage.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/debug_mailbox_wb.sv
`default_nettype none
// ============================================================================
// Module   : debug_mailbox_wb
// Purpose  : Wishbone B4 pipelined debug/test-status slave. Firmware writes a
//            result code, streams console bytes through a FIFO, reads a
//            free-running cycle counter and arms a watchdog.
// Ports    : wb_clk_i, wb_rst_i     - clock, synchronous active-high reset
//            wb_cyc_i .. wb_sel_i   - Wishbone slave request
//            wb_stall_o             - tied 0
//            wb_ack_o / wb_err_o    - response, one cycle after accept
//            wb_dat_o               - read data, valid with ack
//            con_data_o/valid_o     - console FIFO head
//            con_ready_i            - console consumer ready (pop)
//            done_o, pass_o, fail_o - test status
//            timeout_o              - watchdog expired (sticky)
// Map      : 0 RESULT, 1 CONSOLE, 2 CON_STAT, 3 CYCLES, 4 WDT; 5..7 -> err
// Options  : DEBUG_MAILBOX_SIM_EN - simulation-only messages and $finish
//            on completion, console echo via $write
// Revision : 1.0 - initial release
// ============================================================================
module debug_mailbox_wb
  import debug_mailbox_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] PASS_CODE  = DEFAULT_PASS_CODE,
  parameter logic [31:0] FAIL_CODE  = DEFAULT_FAIL_CODE,
  parameter int          WDT_W      = 32
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_stall_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [31:0] wb_dat_o,
  output logic [7:0]  con_data_o,
  output logic        con_valid_o,
  input  logic        con_ready_i,
  output logic        done_o,
  output logic        pass_o,
  output logic        fail_o,
  output logic        timeout_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // ---------------------------------------------------------------- decode
  logic       accept;
  logic [2:0] reg_off;
  logic       mapped;
  logic       wr_en;
  logic       rd_en;

  assign accept  = wb_cyc_i & wb_stb_i;
  assign reg_off = wb_adr_i[4:2];
  assign mapped  = (reg_off <= REG_WDT);
  assign wr_en   = accept &  wb_we_i & mapped;
  assign rd_en   = accept & ~wb_we_i & mapped;

  assign wb_stall_o = 1'b0;

  // Address bits outside the register select are don't-care.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

  // ---------------------------------------------------------------- state
  logic [31:0]      result;
  logic             result_written;
  logic [31:0]      cycles;
  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_armed;
  logic             timeout;
  logic             overflow;

  // ---------------------------------------------------------------- console FIFO
  logic             con_push;
  logic             con_pop;
  logic             con_full;
  logic             con_empty;
  logic [CNT_W-1:0] con_count;

  assign con_push    = wr_en & (reg_off == REG_CONSOLE) & wb_sel_i[0];
  assign con_valid_o = ~con_empty;
  assign con_pop     = con_valid_o & con_ready_i;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_con_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (con_push),
    .push_data (wb_dat_i[7:0]),
    .pop       (con_pop),
    .pop_data  (con_data_o),
    .full      (con_full),
    .empty     (con_empty),
    .count     (con_count)
  );

  // ---------------------------------------------------------------- read mux
  logic [15:0] con_count16;
  logic [31:0] wdt_rd;
  logic [31:0] rd_mux;

  always_comb begin
    con_count16 = '0;
    con_count16[CNT_W-1:0] = con_count;
  end

  always_comb begin
    wdt_rd = '0;
    wdt_rd[WDT_W-1:0] = wdt_cnt;
  end

  always_comb begin
    rd_mux = '0;
    case (reg_off)
      REG_RESULT: rd_mux = result;
      REG_CON_STAT: begin
        rd_mux[CON_STAT_OVF_BIT]   = overflow;
        rd_mux[CON_STAT_CNT_MSB:0] = con_count16;
      end
      REG_CYCLES: rd_mux = cycles;
      REG_WDT:    rd_mux = wdt_rd;
      default:    rd_mux = '0;
    endcase
  end

  // ---------------------------------------------------------------- bus response
  // Reset has priority, so an access accepted in the reset cycle never answers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= accept &  mapped;
      wb_err_o <= accept & ~mapped;
      wb_dat_o <= rd_en ? rd_mux : 32'd0;
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      result         <= '0;
      result_written <= 1'b0;
      cycles         <= '0;
      overflow       <= 1'b0;
    end else begin
      cycles <= cycles + 32'd1;

      if (wr_en && (reg_off == REG_RESULT)) begin
        result         <= merge_bytes(result, wb_dat_i, wb_sel_i);
        result_written <= 1'b1;
      end

      // A push into a full FIFO is only lost if nothing leaves this cycle.
      if (con_push && con_full && !con_pop) begin
        overflow <= 1'b1;
      end else if (wr_en && (reg_off == REG_CON_STAT) && wb_sel_i[3] &&
                   wb_dat_i[CON_STAT_OVF_BIT]) begin
        overflow <= 1'b0;
      end
    end
  end

  // Watchdog: a bus load overrides the running decrement in the same cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wdt_cnt   <= '0;
      wdt_armed <= 1'b0;
      timeout   <= 1'b0;
    end else if (wr_en && (reg_off == REG_WDT)) begin
      wdt_cnt   <= wb_dat_i[WDT_W-1:0];
      wdt_armed <= |wb_dat_i[WDT_W-1:0];
    end else if (wdt_armed) begin
      wdt_cnt <= wdt_cnt - WDT_W'(1);
      if (wdt_cnt == WDT_W'(1)) begin
        wdt_armed <= 1'b0;
        timeout   <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- status
  // result_written gates the decode so a cleared result never reads as a code.
  assign timeout_o = timeout;
  assign done_o    = result_written | timeout;
  assign pass_o    = result_written & (result == PASS_CODE);
  assign fail_o    = (result_written & (result == FAIL_CODE)) | timeout;

`ifdef DEBUG_MAILBOX_SIM_EN
  logic done_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_o;
      if (con_pop) $write("%c", con_data_o);
      if (done_o && !done_q) begin
        if (timeout)                  $display("Timeout!");
        else if (result == PASS_CODE) $display("Success!");
        else if (result == FAIL_CODE) $display("Failure!");
        else                          $display("Non-determined data: %0d", result);
        $finish;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_debug_mailbox_wb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_debug_mailbox_wb
// Purpose  : Directed self-checking bench for debug_mailbox_wb (default
//            parameters: FIFO_DEPTH 16, PASS 1, FAIL 31, WDT_W 32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_mailbox_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = '0;
  logic        stall;
  logic        ack;
  logic        err;
  logic [31:0] rdat;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready = 1'b0;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debug_mailbox_wb dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wb_cyc_i    (cyc),
    .wb_stb_i    (stb),
    .wb_we_i     (we),
    .wb_adr_i    (adr),
    .wb_dat_i    (wdat),
    .wb_sel_i    (sel),
    .wb_stall_o  (stall),
    .wb_ack_o    (ack),
    .wb_err_o    (err),
    .wb_dat_o    (rdat),
    .con_data_o  (con_data),
    .con_valid_o (con_valid),
    .con_ready_i (con_ready),
    .done_o      (done),
    .pass_o      (pass),
    .fail_o      (fail),
    .timeout_o   (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Single access: drive on negedge, accepted at next posedge, sample 1ns later.
  task automatic bus(input logic b_we, input logic [31:0] b_adr, input logic [31:0] b_dat,
                     input logic [3:0] b_sel, output logic o_ack, output logic o_err,
                     output logic [31:0] o_dat);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = b_we; adr = b_adr; wdat = b_dat; sel = b_sel;
    @(posedge clk); #1;
    o_ack = ack; o_err = err; o_dat = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] w_adr, input logic [31:0] w_dat, input logic [3:0] w_sel);
    logic a, e;
    logic [31:0] d;
    bus(1'b1, w_adr, w_dat, w_sel, a, e, d);
    check("wr_ack", {31'b0, a}, 32'd1);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] r_adr, input logic [31:0] exp);
    logic a, e;
    logic [31:0] d;
    bus(1'b0, r_adr, 32'd0, 4'hF, a, e, d);
    check(tag, d, exp);
    check({tag, "_ack"}, {31'b0, a}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; con_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic a, e;
    logic [31:0] d;

    // ---------------- reset state
    do_reset();
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_dat", rdat, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_status", {28'b0, done, pass, fail, timeout}, 32'd0);
    check("rst_con_valid", {31'b0, con_valid}, 32'd0);

    // ---------------- RESULT
    wr(32'h0, 32'd1, 4'hF);
    check("res1_status", {29'b0, done, pass, fail}, 32'b110);
    rd_check("res1_read", 32'h0, 32'd1);
    wr(32'h0, 32'd31, 4'hF);
    check("res31_status", {29'b0, done, pass, fail}, 32'b101);
    wr(32'h0, 32'd1, 4'hF);
    wr(32'h0, 32'h0000_00FF, 4'b0001);
    check("resff_status", {29'b0, done, pass, fail}, 32'b100);
    rd_check("resff_read", 32'h0, 32'h0000_00FF);
    wr(32'h0, 32'hAB00_0000, 4'b1000);
    rd_check("res_lane3", 32'h0, 32'hAB00_00FF);
    rd_check("console_read", 32'h4, 32'd0);

    // ---------------- console overflow and drain
    for (int i = 0; i < 17; i++) wr(32'h4, 32'h41 + i, 4'b0001);
    rd_check("constat_ovf", 32'h8, 32'h8000_0010);
    check("con_head", {24'b0, con_data}, 32'h41);
    @(negedge clk);
    con_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("con_pop", {24'b0, con_data}, 32'h41 + i);
      @(negedge clk);
    end
    con_ready = 1'b0;
    check("con_empty", {31'b0, con_valid}, 32'd0);
    rd_check("constat_drained", 32'h8, 32'h8000_0000);
    wr(32'h8, 32'h8000_0000, 4'b1000);
    rd_check("constat_clr", 32'h8, 32'h0000_0000);

    // ---------------- push + pop while full
    for (int i = 0; i < 16; i++) wr(32'h4, 32'h60 + i, 4'b0001);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h4; wdat = 32'h70; sel = 4'b0001;
    con_ready = 1'b1;
    @(posedge clk); #1;
    check("fullpp_ack", {31'b0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; con_ready = 1'b0;
    rd_check("fullpp_stat", 32'h8, 32'h0000_0010);
    @(negedge clk);
    con_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("fullpp_pop", {24'b0, con_data}, (i < 15) ? (32'h61 + i) : 32'h70);
      @(negedge clk);
    end
    con_ready = 1'b0;
    check("fullpp_empty", {31'b0, con_valid}, 32'd0);

    // ---------------- watchdog basic expiry
    do_reset();
    wr(32'h10, 32'd5, 4'hF);
    check("wdt_armed", {30'b0, done, timeout}, 32'd0);
    repeat (4) @(posedge clk);
    #1 check("wdt_early", {31'b0, timeout}, 32'd0);
    @(posedge clk);
    #1 check("wdt_expire", {28'b0, done, pass, fail, timeout}, 32'b1011);

    // ---------------- watchdog reload
    do_reset();
    wr(32'h10, 32'd5, 4'hF);
    repeat (2) @(posedge clk);
    wr(32'h10, 32'd5, 4'hF);
    rd_check("wdt_remaining", 32'h10, 32'd5);
    repeat (3) @(posedge clk);
    #1 check("wdt_reload_early", {31'b0, timeout}, 32'd0);
    @(posedge clk);
    #1 check("wdt_reload_expire", {31'b0, timeout}, 32'd1);
    rd_check("wdt_after", 32'h10, 32'd0);

    // ---------------- watchdog disarm
    do_reset();
    wr(32'h10, 32'd5, 4'hF);
    wr(32'h10, 32'd0, 4'hF);
    repeat (10) @(posedge clk);
    #1 check("wdt_disarm", {30'b0, done, timeout}, 32'd0);

    // ---------------- timeout coinciding with a RESULT write
    do_reset();
    wr(32'h10, 32'd3, 4'hF);
    repeat (2) @(posedge clk);
    wr(32'h0, 32'd1, 4'hF);
    check("coinc_status", {29'b0, done, fail, timeout}, 32'b111);
    rd_check("coinc_result", 32'h0, 32'd1);

    // ---------------- unmapped offsets
    bus(1'b1, 32'h14, 32'hDEAD_BEEF, 4'hF, a, e, d);
    check("err_wr", {29'b0, a, e, |d}, 32'b010);
    bus(1'b0, 32'h1C, 32'd0, 4'hF, a, e, d);
    check("err_rd", {29'b0, a, e, |d}, 32'b010);
    rd_check("err_no_side_effect", 32'h0, 32'd1);

    // ---------------- pipelined CYCLES burst straight out of reset
    do_reset();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'hC; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("burst_ack", {30'b0, ack, err}, 32'b10);
      check("burst_dat", rdat, i);
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check("burst_end", {30'b0, ack, err}, 32'd0);

    // ---------------- reset during a pending response
    wr(32'h0, 32'd1, 4'hF);
    wr(32'h4, 32'h55, 4'b0001);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; sel = 4'hF;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_resp", {30'b0, ack, err}, 32'd0);
    check("rstmid_dat", rdat, 32'd0);
    check("rstmid_status", {27'b0, done, pass, fail, timeout, con_valid}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
